// File: rtl/video_timing_pkg.sv
// Shared timing constants, counter/colour types and helpers for the HDMI raster generator.
package video_timing_pkg;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned COORD_W = 11;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [23:0]        rgb_t;

    localparam rgb_t RGB_BLACK = '0;

    // 1920x1080 @ 60 Hz
    localparam int unsigned P1080_H_SYNC  = 44;
    localparam int unsigned P1080_H_BACK  = 148;
    localparam int unsigned P1080_H_DISP  = 1920;
    localparam int unsigned P1080_H_FRONT = 88;
    localparam int unsigned P1080_V_SYNC  = 5;
    localparam int unsigned P1080_V_BACK  = 36;
    localparam int unsigned P1080_V_DISP  = 1080;
    localparam int unsigned P1080_V_FRONT = 4;

    // 1280x720 @ 60 Hz
    localparam int unsigned P720_H_SYNC  = 40;
    localparam int unsigned P720_H_BACK  = 220;
    localparam int unsigned P720_H_DISP  = 1280;
    localparam int unsigned P720_H_FRONT = 110;
    localparam int unsigned P720_V_SYNC  = 5;
    localparam int unsigned P720_V_BACK  = 20;
    localparam int unsigned P720_V_DISP  = 720;
    localparam int unsigned P720_V_FRONT = 5;

    // Number of counts in one axis period (line length or frame height).
    function automatic int unsigned axis_total(input int unsigned sync, input int unsigned back,
                                               input int unsigned disp, input int unsigned front);
        return sync + back + disp + front;
    endfunction

endpackage

// File: rtl/timing_axis_cnt.sv
// One raster axis: wrapping position counter plus sync/active/request window decodes.
module timing_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int unsigned SYNC  = P1080_H_SYNC,
    parameter int unsigned BACK  = P1080_H_BACK,
    parameter int unsigned DISP  = P1080_H_DISP,
    parameter int unsigned FRONT = P1080_H_FRONT,
    parameter int unsigned LEAD  = 0
) (
    input  logic             pixel_clk,
    input  logic             sys_rst,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sync_o,
    output logic             active_o,
    output logic             req_o
);

    localparam cnt_t LAST    = cnt_t'(axis_total(SYNC, BACK, DISP, FRONT) - 1);
    localparam cnt_t SYNC_HI = cnt_t'(SYNC);
    localparam cnt_t ACT_LO  = cnt_t'(SYNC + BACK);
    localparam cnt_t ACT_HI  = cnt_t'(SYNC + BACK + DISP);
    localparam cnt_t REQ_LO  = cnt_t'(SYNC + BACK - LEAD);
    localparam cnt_t REQ_HI  = cnt_t'(SYNC + BACK + DISP - LEAD);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Next position: hold, step, or wrap to zero at the end of the period.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + cnt_t'(1);
        end
    end

    // Position register with synchronous reset to the start of the period.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wrap_o   = (cnt_q == LAST);
    assign sync_o   = (cnt_q < SYNC_HI);
    assign active_o = (cnt_q >= ACT_LO) && (cnt_q < ACT_HI);
    assign req_o    = (cnt_q >= REQ_LO) && (cnt_q < REQ_HI);

endmodule

// File: rtl/video_timing_driver.sv
// Raster timing generator: sync/DE to the HDMI encoder and one-cycle-early pixel requests.
module video_timing_driver
    import video_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = P1080_H_SYNC,
    parameter int unsigned H_BACK   = P1080_H_BACK,
    parameter int unsigned H_DISP   = P1080_H_DISP,
    parameter int unsigned H_FRONT  = P1080_H_FRONT,
    parameter int unsigned V_SYNC   = P1080_V_SYNC,
    parameter int unsigned V_BACK   = P1080_V_BACK,
    parameter int unsigned V_DISP   = P1080_V_DISP,
    parameter int unsigned V_FRONT  = P1080_V_FRONT,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic         pixel_clk,
    input  logic         sys_rst,
    input  logic [23:0]  pixel_data,
    output logic [10:0]  pixel_xpos,
    output logic [10:0]  pixel_ypos,
    output logic         data_req,
    output logic         video_hs,
    output logic         video_vs,
    output logic         video_de,
    output logic [23:0]  video_rgb,
    output logic         frame_start
);

    localparam cnt_t X_OFS = cnt_t'(H_SYNC + H_BACK - 1);
    localparam cnt_t Y_OFS = cnt_t'(V_SYNC + V_BACK);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_wrap, h_sync, h_act, h_req;
    logic v_sync, v_act, v_req;

    timing_axis_cnt #(
        .SYNC (H_SYNC),
        .BACK (H_BACK),
        .DISP (H_DISP),
        .FRONT(H_FRONT),
        .LEAD (1)
    ) u_h_axis (
        .pixel_clk(pixel_clk),
        .sys_rst  (sys_rst),
        .inc_i    (1'b1),
        .cnt_o    (h_cnt),
        .wrap_o   (h_wrap),
        .sync_o   (h_sync),
        .active_o (h_act),
        .req_o    (h_req)
    );

    // The vertical wrap condition is implied by h_wrap gating the increment.
    timing_axis_cnt #(
        .SYNC (V_SYNC),
        .BACK (V_BACK),
        .DISP (V_DISP),
        .FRONT(V_FRONT),
        .LEAD (0)
    ) u_v_axis (
        .pixel_clk(pixel_clk),
        .sys_rst  (sys_rst),
        .inc_i    (h_wrap),
        .cnt_o    (v_cnt),
        .wrap_o   (),
        .sync_o   (v_sync),
        .active_o (v_act),
        .req_o    (v_req)
    );

    // Output decode of the counter registers; pixel_data only reaches video_rgb via the DE gate.
    always_comb begin
        video_hs    = h_sync ? SYNC_POL : ~SYNC_POL;
        video_vs    = v_sync ? SYNC_POL : ~SYNC_POL;
        video_de    = h_act & v_act;
        data_req    = h_req & v_req;
        pixel_xpos  = '0;
        pixel_ypos  = '0;
        if (data_req) begin
            pixel_xpos = coord_t'(h_cnt - X_OFS);
            pixel_ypos = coord_t'(v_cnt - Y_OFS);
        end
        video_rgb   = video_de ? pixel_data : RGB_BLACK;
        frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule
